// File: rtl/sumador_segmentado.sv
// sumador_segmentado: pipelined ripple-carry adder/subtractor, one SW-bit slice per stage.
// Optional signed-overflow output is built only when SUMADOR_OVERFLOW_EN is defined.
module sumador_segmentado #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             carry_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef SUMADOR_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int SW = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_param
    $error("sumador_segmentado: WIDTH must be a multiple of STAGES");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer keeps data stable while valid && !ready, and ready never waits on valid.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet summed when the op enters this stage; slice k sits at the bottom.
    localparam int AW = WIDTH - SW * k;

    logic                v_in;
    logic                c_in;
    logic [AW-1:0]       a_src;
    logic [AW-1:0]       b_src;
    logic [SW*(k+1)-1:0] res_d;
    logic [SW:0]         sum;
    logic                take;
    logic                load;
    logic                v_q;
    logic                c_q;
    logic [SW*(k+1)-1:0] res_q;

    if (k == 0) begin : g_head
      assign v_in  = in_valid;
      assign c_in  = op_sub | carry_in;
      assign a_src = OpA;
      assign b_src = op_sub ? ~OpB : OpB;
      assign res_d = sum[SW-1:0];
    end else begin : g_body
      assign v_in  = g_stage[k-1].v_q;
      assign c_in  = g_stage[k-1].c_q;
      assign a_src = g_stage[k-1].g_fwd.a_q;
      assign b_src = g_stage[k-1].g_fwd.b_q;
      assign res_d = {sum[SW-1:0], g_stage[k-1].res_q};
    end

    // A stage can take new contents when empty or when its occupant moves on this edge.
    if (k == STAGES - 1) begin : g_last_ready
      assign take = !v_q || out_ready;
    end else begin : g_mid_ready
      assign take = !v_q || g_stage[k+1].take;
    end

    assign load = v_in && take;
    assign sum  = {1'b0, a_src[SW-1:0]} + {1'b0, b_src[SW-1:0]} + {{SW{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else begin
        if (take) begin
          v_q <= v_in;
        end
        if (load) begin
          c_q   <= sum[SW];
          res_q <= res_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [AW-SW-1:0] a_q;
      logic [AW-SW-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_src[AW-1:SW];
          b_q <= b_src[AW-1:SW];
        end
      end
    end
  end

  assign in_ready  = g_stage[0].take;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign result    = g_stage[STAGES-1].res_q;
  assign carry_out = g_stage[STAGES-1].c_q;

`ifdef SUMADOR_OVERFLOW_EN
  // The last stage sees the operand MSBs and the result MSB in the same cycle.
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (g_stage[STAGES-1].a_src[SW-1] == g_stage[STAGES-1].b_src[SW-1]) &&
                 (g_stage[STAGES-1].sum[SW-1] != g_stage[STAGES-1].a_src[SW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (g_stage[STAGES-1].load) begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_sumador_segmentado.sv
// Self-checking bench for sumador_segmentado (WIDTH=16, STAGES=4).
// Define SUMADOR_OVERFLOW_EN for both files to exercise the overflow output.
module tb_sumador_segmentado;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int EW     = WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             ovf_obs;
`ifdef SUMADOR_OVERFLOW_EN
  logic             overflow;
  assign ovf_obs = overflow;
`else
  assign ovf_obs = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {overflow, carry_out, result} per accepted op, oldest first.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  logic          held_v;
  logic [EW-1:0] held_obs;
  logic          last_ovf;

  sumador_segmentado #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .OpA       (op_a),
    .OpB       (op_b),
    .carry_in  (carry_in),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out)
`ifdef SUMADOR_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic cin, input logic sub);
    int ua, ub, us, sa, sb, ss;
    logic [WIDTH-1:0] r;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      us = ua - ub;
      c  = (ua >= ub);
      ss = sa - sb;
    end else begin
      us = ua + ub + int'(cin);
      c  = (us >= 65536);
      ss = sa + sb + int'(cin);
    end
    r = us[WIDTH-1:0];
    o = (ss > 32767) || (ss < -32768);
    return {o, c, r};
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(op_a, op_b, carry_in, op_sub));
      if (held_v) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({ovf_obs, carry_out, result}), 32'(held_obs));
      end
      held_v   = out_valid && !out_ready;
      held_obs = {ovf_obs, carry_out, result};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("sb_result", 32'(result), 32'(exp_e[WIDTH-1:0]));
          check("sb_carry", 32'(carry_out), 32'(exp_e[WIDTH]));
`ifdef SUMADOR_OVERFLOW_EN
          check("sb_overflow", 32'(overflow), 32'(exp_e[WIDTH+1]));
`endif
        end
      end
    end
  end

  // Driver: present an op and return just after the edge that accepts it.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, output bit ok);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    carry_in = cin;
    op_sub   = sub;
    ok       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Single op with out_ready high: checks latency and the result against hand-derived values.
  task automatic run_one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub,
                         input logic [WIDTH-1:0] exp_r, input logic exp_c);
    bit ok;
    int lat;
    send(a, b, cin, sub, ok);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(STAGES - 1));
    check({tag, "_result"}, 32'(result), 32'(exp_r));
    check({tag, "_carry"}, 32'(carry_out), 32'(exp_c));
    last_ovf = ovf_obs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    carry_in  = 1'b0;
    op_sub    = 1'b0;
    out_ready = 1'b1;
    last_ovf  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-stream with three ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h8421, WIDTH'($urandom), 1'b1, 1'b0, ok);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t1_setup_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_out_valid", 32'(out_valid), 32'd0);
    check("t1_rst_result", 32'(result), 32'h0);
    check("t1_rst_carry", 32'(carry_out), 32'd0);
    check("t1_rst_overflow", 32'(ovf_obs), 32'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    #1;
    check("t1_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t1_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Directed arithmetic
    run_one("t2_slice_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
    run_one("t3_full_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    run_one("t4_sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_one("t4_sub_cin_ign", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);

    // Backpressure: eight back-to-back ops, consumer stalls for six cycles
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ok);
        end
        in_valid = 1'b0;
      end
      begin
        w = 0;
        while (w < 50) begin
          @(negedge clk);
          if (out_valid) break;
          w++;
        end
        check("t5_first_valid", 32'(w < 50), 32'd1);
        for (int i = 0; i < 6; i++) begin
          if (i > 0) @(negedge clk);
          check("t5_hold_valid", 32'(out_valid), 32'd1);
          check("t5_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          check("t5_stream", 32'(out_valid), 32'd1);
        end
      end
    join
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("t5_all_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

`ifdef SUMADOR_OVERFLOW_EN
    // Signed overflow
    run_one("t6_add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
    check("t6_add_ovf_flag", 32'(last_ovf), 32'd1);
    run_one("t6_sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
    check("t6_sub_ovf_flag", 32'(last_ovf), 32'd1);
    run_one("t6_no_ovf", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    check("t6_no_ovf_flag", 32'(last_ovf), 32'd0);
`endif

    // Random traffic with random backpressure, checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      op_a      = WIDTH'($urandom);
      op_b      = WIDTH'($urandom);
      carry_in  = 1'($urandom_range(0, 1));
      op_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("rand_all_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    check("rand_idle_valid", 32'(out_valid), 32'd0);
    check("rand_idle_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
